// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, command and limit definitions for the ALU issue stage
package alu_pkg;

    // Default operand MSB; the issue stage can be built wider through its own parameter
    localparam int ALU_MSB = 5;

    // Highest legal opcode; anything above makes the ALU pass operand A through
    localparam logic [3:0] ALU_OP_MAX = 4'd7;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_ABSDIFF = 4'd1,
        ALU_GT      = 4'd2,
        ALU_AND     = 4'd3,
        ALU_OR      = 4'd4,
        ALU_XOR     = 4'd5,
        ALU_PASSA   = 4'd6,
        ALU_PASSB   = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_MSB:0] a;
        logic [ALU_MSB:0] b;
        logic [3:0]       sel;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with extra-MSB pointers, head exposed combinationally
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter type cmd_t = alu_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the low bits match
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; a full FIFO refuses pushes even if the head leaves this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because empty gates every consumer
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALU issue stage: command FIFO, operand drive, registered result slot (option ALU_ISSUE_STATS_EN)
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int width = 5,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [width:0] cmd_a,
    input  logic [width:0] cmd_b,
    input  logic [3:0]     cmd_sel,
    output logic [width:0] alu_a,
    output logic [width:0] alu_b,
    output logic [3:0]     alu_sel,
    input  logic [width:0] alu_x,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [width:0] res_x,
    output logic [3:0]     res_sel,
    output logic           res_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]    stat_ops,
    output logic [15:0]    stat_errs
`endif
);

    typedef struct packed {
        logic [width:0] a;
        logic [width:0] b;
        logic [3:0]     sel;
    } cmd_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e state;
    slot_e state_next;
    cmd_t  in_cmd;
    cmd_t  head;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;

    assign in_cmd    = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // Slot state is used directly rather than res_valid to keep the FSM process loop-free
    assign pop       = !empty && ((state == SLOT_EMPTY) || res_ready);

    alu_cmd_fifo #(
        .cmd_t (cmd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Idle ALU inputs are held at zero so the ALU never sees stale FIFO contents
    assign alu_a   = empty ? '0   : head.a;
    assign alu_b   = empty ? '0   : head.b;
    assign alu_sel = empty ? 4'd0 : head.sel;

    // Result slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Result slot next state: a pop refills the slot in the same edge it drains
    always_comb begin
        state_next = state;
        res_valid  = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (pop) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                res_valid = 1'b1;
                if (res_ready && !pop) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Capture the ALU output for the head command as it leaves the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            res_x   <= '0;
            res_sel <= 4'd0;
            res_err <= 1'b0;
        end else if (pop) begin
            res_x   <= alu_x;
            res_sel <= head.sel;
            res_err <= (head.sel > ALU_OP_MAX);
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating counters of delivered results and delivered illegal-opcode results
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= 16'd0;
            stat_errs <= 16'd0;
        end else if (res_valid && res_ready) begin
            if (stat_ops != 16'hFFFF) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (res_err && (stat_errs != 16'hFFFF)) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - self-checking bench for alu_op_issue with attached ALU model (option ALU_ISSUE_STATS_EN)
module tb_alu_op_issue;
    import alu_pkg::*;

    localparam int W = 5;
    localparam int D = 4;

    typedef struct packed {
        logic [W:0] x;
        logic [3:0] sel;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [W:0] cmd_a;
    logic [W:0] cmd_b;
    logic [3:0] cmd_sel;
    logic [W:0] alu_a;
    logic [W:0] alu_b;
    logic [3:0] alu_sel;
    logic [W:0] alu_x;
    logic       res_valid;
    logic       res_ready;
    logic [W:0] res_x;
    logic [3:0] res_sel;
    logic       res_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    res_t sb[$];
    res_t sb_exp;
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    int   delivered_errs = 0;
    bit   x_chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_op_issue #(.width(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_x     (alu_x),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_x     (res_x),
        .res_sel   (res_sel),
        .res_err   (res_err)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    function automatic logic [W:0] alu_ref(input logic [W:0] a, input logic [W:0] b, input logic [3:0] sel);
        case (sel)
            ALU_ADD:     return a + b;
            ALU_ABSDIFF: return (a > b) ? (a - b) : (b - a);
            ALU_GT:      return {{W{1'b0}}, (a > b)};
            ALU_AND:     return a & b;
            ALU_OR:      return a | b;
            ALU_XOR:     return a ^ b;
            ALU_PASSA:   return a;
            ALU_PASSB:   return b;
            default:     return a;
        endcase
    endfunction

    // Combinational ALU attached to the issue stage
    always_comb alu_x = alu_ref(alu_a, alu_b, alu_sel);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: accepted commands push expectations, delivered results pop and compare
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            delivered      = 0;
            delivered_errs = 0;
        end else begin
            if (x_chk_en) begin
                check("no_x", {31'd0, $isunknown({cmd_ready, res_valid, res_x, res_sel, res_err, alu_a, alu_b, alu_sel})}, 32'd0);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {31'd0, res_valid}, 32'd0);
                end else begin
                    sb_exp = sb.pop_front();
                    check("sb_res_x", res_x, sb_exp.x);
                    check("sb_res_sel", res_sel, sb_exp.sel);
                    check("sb_res_err", res_err, sb_exp.err);
                    delivered++;
                    if (sb_exp.err) delivered_errs++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{x: alu_ref(cmd_a, cmd_b, cmd_sel), sel: cmd_sel, err: (cmd_sel > 4'd7)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and return just after the edge that accepted it
    task automatic send(input logic [W:0] a, input logic [W:0] b, input logic [3:0] sel);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) check("send_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(tag, {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        int d0;
        logic [31:0] r;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = 4'd0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        x_chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_x", res_x, 0);
        check("rst_res_sel", res_sel, 0);
        check("rst_res_err", res_err, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_sel", alu_sel, 0);
`ifdef ALU_ISSUE_STATS_EN
        check("rst_stat_ops", stat_ops, 0);
        check("rst_stat_errs", stat_errs, 0);
`endif
        tick();

        // Single add, latency
        send(6'd10, 6'd20, 4'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_alu_a", alu_a, 10);
        check("t1_alu_b", alu_b, 20);
        check("t1_not_yet_valid", res_valid, 0);
        tick();
        @(negedge clk);
        check("t1_res_valid", res_valid, 1);
        check("t1_res_x", res_x, 30);
        check("t1_res_sel", res_sel, 0);
        check("t1_res_err", res_err, 0);
        tick();

        // Back-to-back throughput
        send(6'd5, 6'd12, 4'd1);
        send(6'd40, 6'd3, 4'd2);
        send(6'h2A, 6'h0F, 4'd5);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t2_second_valid", res_valid, 1);
        check("t2_second_x", res_x, 1);
        tick();
        @(negedge clk);
        check("t2_third_valid", res_valid, 1);
        check("t2_third_x", res_x, 6'h25);
        tick();
        @(negedge clk);
        check("t2_drained", res_valid, 0);
        tick();

        // Back-pressure: fill FIFO and slot, then release
        d0 = delivered;
        res_ready = 1'b0;
        send(6'd1, 6'd2, 4'd0);
        send(6'd63, 6'd1, 4'd0);
        send(6'd7, 6'd9, 4'd1);
        send(6'h33, 6'h0F, 4'd3);
        send(6'h30, 6'h0C, 4'd4);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t3_full_ready", cmd_ready, 0);
        check("t3_slot_valid", res_valid, 1);
        check("t3_slot_x", res_x, 3);
        tick();
        tick();
        @(negedge clk);
        check("t3_hold_x", res_x, 3);
        check("t3_hold_sel", res_sel, 0);
        check("t3_still_full", cmd_ready, 0);
        tick();
        res_ready = 1'b1;
        send(6'd6, 6'd5, 4'd7);
        cmd_valid = 1'b0;
        repeat (10) tick();
        check("t3_sb_empty", sb.size(), 0);
        check("t3_delivered", delivered - d0, 6);

        // Illegal opcode
        send(6'd9, 6'd3, 4'd9);
        cmd_valid = 1'b0;
        wait_valid("t4_valid");
        check("t4_res_x", res_x, 9);
        check("t4_res_sel", res_sel, 9);
        check("t4_res_err", res_err, 1);
        tick();
        @(negedge clk);
        #1;
`ifdef ALU_ISSUE_STATS_EN
        check("t4_stat_errs", stat_errs, 1);
        check("t4_stat_ops", stat_ops, delivered);
`endif
        tick();

        // Reset with queued work and a pending result
        res_ready = 1'b0;
        send(6'd1, 6'd1, 4'd0);
        send(6'd2, 6'd2, 4'd0);
        send(6'd3, 6'd3, 4'd0);
        send(6'd4, 6'd4, 4'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_pending", res_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_res_valid", res_valid, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_alu_a", alu_a, 0);
        check("t5_res_x", res_x, 0);
`ifdef ALU_ISSUE_STATS_EN
        check("t5_stat_ops", stat_ops, 0);
`endif
        tick();
        res_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t5_no_stale", res_valid, 0);
        end
        tick();

        // Random push/stall traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            r         = $urandom;
            cmd_valid = (r[23:22] != 2'd0);
            cmd_a     = r[W:0];
            cmd_b     = r[W+8:8];
            cmd_sel   = r[19:16];
            res_ready = (r[27:25] > 3'd2);
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (12) tick();
        check("t6_sb_empty", sb.size(), 0);
        check("t6_idle", res_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
        check("t6_stat_ops", stat_ops, delivered);
        check("t6_stat_errs", stat_errs, delivered_errs);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
